// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I command encoder feeding a 4-entry output FIFO.
// Optional illegal-command counter enabled by macro INSTR_ENCODER_ERR_CNT_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [11:0] cmd_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
`ifdef INSTR_ENCODER_ERR_CNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        err_illegal
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STR  = 7'b0100011;

    logic [31:0] mem_q [4];
    logic [1:0]  wptr_q, wptr_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;

    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (cmd_op)
            4'd0: enc_word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, OPC_R};
            4'd1: enc_word = {7'b0100000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, OPC_R};
            4'd2: enc_word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b111, cmd_rd, OPC_R};
            4'd3: enc_word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b110, cmd_rd, OPC_R};
            4'd4: enc_word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b010, cmd_rd, OPC_R};
            4'd5: enc_word = {cmd_imm, cmd_rs1, 3'b000, cmd_rd, OPC_IMM};
            4'd6: enc_word = {cmd_imm, cmd_rs1, 3'b010, cmd_rd, OPC_LOAD};
            4'd7: enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], OPC_STR};
            default: legal = 1'b0;
        endcase
    end

    assign cmd_ready = (count_q != 3'd4);
    assign out_valid = (count_q != 3'd0);
    // Gating by out_valid makes the output read 0 as soon as reset clears count.
    assign out_instr = out_valid ? mem_q[rptr_q] : 32'd0;
    assign err_illegal = err_q;

    assign accept = cmd_valid && cmd_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        wptr_d  = wptr_q + {1'b0, push};
        rptr_d  = rptr_q + {1'b0, pop};
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        err_d   = accept && !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: stale entries are never visible once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= enc_word;
        end
    end

`ifdef INSTR_ENCODER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [4:0]  cmd_rd = '0;
    logic [4:0]  cmd_rs1 = '0;
    logic [4:0]  cmd_rs2 = '0;
    logic [11:0] cmd_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err_illegal;
`ifdef INSTR_ENCODER_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_q [$];
    logic        exp_err = 1'b0;
    int          exp_err_cnt = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
`ifdef INSTR_ENCODER_ERR_CNT_EN
        .err_count  (err_count),
`endif
        .err_illegal(err_illegal)
    );

    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input int imm);
        int f3_r [5] = '{0, 0, 7, 6, 2};
        int w;
        w = 0;
        if (op <= 4) begin
            w = ((op == 1) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                + f3_r[op] * (1 << 12) + rd * (1 << 7) + 'h33;
        end else if (op == 5) begin
            w = imm * (1 << 20) + rs1 * (1 << 15) + rd * (1 << 7) + 'h13;
        end else if (op == 6) begin
            w = imm * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + 'h03;
        end else begin
            w = (imm / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                + 2 * (1 << 12) + (imm % 32) * (1 << 7) + 'h23;
        end
        return 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("cmd_ready", 32'(cmd_ready), 32'(model_q.size() < 4));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("out_instr", out_instr, (model_q.size() != 0) ? model_q[0] : 32'd0);
        chk("err_illegal", 32'(err_illegal), 32'(exp_err));
`ifdef INSTR_ENCODER_ERR_CNT_EN
        chk("err_count", 32'(err_count), 32'(exp_err_cnt));
`endif
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input logic v, input int op, input int rd, input int rs1,
                         input int rs2, input int imm, input logic rdy);
        logic acc, xfer;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = 4'(op);
        cmd_rd    = 5'(rd);
        cmd_rs1   = 5'(rs1);
        cmd_rs2   = 5'(rs2);
        cmd_imm   = 12'(imm);
        out_ready = rdy;
        #1;
        check_outputs();
        acc  = v && (model_q.size() < 4);
        xfer = rdy && (model_q.size() != 0);
        @(posedge clk);
        if (xfer) void'(model_q.pop_front());
        if (acc && op < 8) model_q.push_back(ref_encode(op, rd, rs1, rs2, imm));
        exp_err = acc && (op >= 8);
        if (exp_err && exp_err_cnt < 255) exp_err_cnt++;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed encodings, each visible one cycle after acceptance
        cycle(1'b1, 0, 3, 1, 2, 0, 1'b1);
        #2 chk("add_word", out_instr, 32'h002081B3);
        cycle(1'b1, 1, 3, 1, 2, 0, 1'b1);
        #2 chk("sub_word", out_instr, 32'h402081B3);
        cycle(1'b1, 5, 1, 0, 9, 'hFFF, 1'b1);
        #2 chk("addi_word", out_instr, 32'hFFF00093);
        cycle(1'b1, 6, 5, 2, 17, 8, 1'b1);
        #2 chk("lw_word", out_instr, 32'h00812283);
        cycle(1'b1, 7, 21, 2, 6, 12, 1'b1);
        #2 chk("sw_word", out_instr, 32'h00612623);
        idle(1'b1);
        idle(1'b1);

        // Fill with out_ready low; fifth command stalls until a slot frees
        for (int i = 0; i < 5; i++) cycle(1'b1, i, i + 1, i + 2, i + 3, 0, 1'b0);
        #2 chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        cycle(1'b1, 4, 5, 6, 7, 0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 4, 5, 6, 7, 0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Illegal command: nothing written, single-cycle error pulse
        cycle(1'b1, 9, 1, 1, 1, 0, 1'b1);
        #2 chk("illegal_pulse", 32'(err_illegal), 32'd1);
        chk("illegal_no_valid", 32'(out_valid), 32'd0);
`ifdef INSTR_ENCODER_ERR_CNT_EN
        chk("illegal_count", 32'(err_count), 32'd1);
`endif
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset with 3 words buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, i, i, i, 0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_out_instr", out_instr, 32'd0);
        model_q.delete();
        exp_err = 1'b0;
        exp_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        cycle(1'b1, 2, 7, 8, 9, 0, 1'b1);
        #2 chk("post_reset_word", out_instr, ref_encode(2, 7, 8, 9, 0));

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
